alu_ctrl_issue: RTL and testbench
=================================

Name: alu_ctrl_issue

Overview:
- Initiator side of the ALU control interface. Accepts decoded-instruction fields (ALUOp, funct) on a valid/ready handshake and emits the registered 4-bit ALUCtrl code consumed by the ALU.
- Sequences multiply as a multi-cycle operation and holds the pipeline with a stall signal.
- Sits between the ID/EX register and the ALU.

Parameters:
- MUL_LAT, 4, cycles the ALU needs for multiply (legal range 1..15)

Ports:
- clk_i  input  1  clock; all state changes on rising edge
- rst_i  input  1  asynchronous, active-low reset
- valid_i  input  1  upstream has an op to issue
- ready_o  output  1  block accepts op this cycle
- ALUOp_i  input  2  main-control ALU op class
- funct_i  input  6  R-type funct field
- ALUCtrl_o  output  4  registered ALU control code
- valid_o  output  1  ALUCtrl_o is final and result is usable
- ready_i  input  1  downstream consumes the issued op
- stall_o  output  1  multiply in progress; freeze upstream stages
- err_o  output  1  sticky illegal-funct flag (see Optional Feature)

Behaviour:
- Decode, registered on accept:
  - ALUOp 00 -> 0010 (add)
  - ALUOp 01 -> 0110 (sub)
  - ALUOp 11 -> 0001 (or)
  - ALUOp 10 by funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 011000 -> 0011 (mult)
  - Any other funct with ALUOp 10 is illegal and decodes to 0010.
- FSM states: IDLE, ISSUE, MUL_WAIT.
- ready_o is combinational: 1 in IDLE; equals ready_i in ISSUE; 0 in MUL_WAIT; 0 while rst_i low.
- Accept occurs when valid_i && ready_o.
  - Non-mult accept -> ISSUE.
  - Mult accept -> MUL_WAIT with cnt = MUL_LAT-1.
- IDLE: valid_o=0, stall_o=0. On accept, ALUCtrl_o loads the decoded code.
- ISSUE: valid_o=1; ALUCtrl_o held until ready_i.
  - ready_i && accept: back-to-back; reload ALUCtrl_o, next state per the accept rule.
  - ready_i && !valid_i: -> IDLE.
  - !ready_i: stay in ISSUE.
- MUL_WAIT: ALUCtrl_o held at 0011, valid_o=0, stall_o=1.
  - cnt decrements each cycle.
  - At cnt==0 -> ISSUE.
- Latency:
  - Non-mult: valid_o rises the cycle after accept.
  - Mult: valid_o rises MUL_LAT+1 cycles after accept.
  - MUL_LAT=1 gives exactly one MUL_WAIT cycle.
- cnt is 4 bits wide, counts down only, and has no wrap-around.
- Reset (any time, including mid-MUL_WAIT):
  - State goes to IDLE, cnt=0, ALUCtrl_o=0010, valid_o=0, stall_o=0, err_o=0.
  - An in-flight op is dropped.
- valid_i while ready_o=0 is ignored; upstream must hold its fields.
- ALUCtrl_o is X-free from reset onward.

Optional Feature:
- Macro ALU_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - err_o sets on accept of an illegal ALUOp 10/funct combination.
  - err_o stays 1 until reset, unaffected by later legal ops.
  - The illegal op still issues as 0010.
- Undefined: err_o tied to 0 and no flag register is built.

Test Plan:
- Reset release, then ALUOp=00, valid_i=1 one cycle, ready_i=1 -> next cycle ALUCtrl_o=0010, valid_o=1; following cycle valid_o=0, state IDLE.
- Back-to-back R-type add, sub, and, or (funct 20h, 22h, 24h, 25h), valid_i and ready_i held 1 -> ALUCtrl_o sequence 0010, 0110, 0000, 0001 on consecutive cycles, ready_o constantly 1.
- Mult (ALUOp=10, funct=18h) with MUL_LAT=4 -> stall_o=1 and ready_o=0 for 4 cycles, ALUCtrl_o=0011 throughout; valid_o=1 on 5th cycle after accept; repeat with MUL_LAT=1 -> one stall cycle.
- Backpressure: issue sub, ready_i=0 for 3 cycles -> valid_o=1 and ALUCtrl_o=0110 stable, ready_o=0; new valid_i held and accepted only when ready_i=1.
- rst_i pulled low during 2nd MUL_WAIT cycle -> valid_o=0, stall_o=0, ALUCtrl_o=0010 immediately; after release, a fresh add issues normally.
- With ALU_CTRL_ILLEGAL_TRAP_EN: funct=3Fh, ALUOp=10 -> ALUCtrl_o=0010, err_o=1 next cycle and still 1 after a legal or; without the macro err_o stays 0.

Source files
------------

// File: rtl/alu_ctrl_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_issue
// Purpose  : Initiator side of the ALU control interface. Accepts decoded
//            ALUOp/funct fields on a valid/ready handshake and presents a
//            registered 4-bit ALUCtrl code to the ALU. Multiply is sequenced
//            as a multi-cycle op, and stall_o freezes upstream stages while
//            it runs.
// Ports    : clk_i      - clock, rising edge
//            rst_i      - asynchronous active-low reset
//            valid_i    - upstream op available
//            ready_o    - op accepted this cycle (combinational)
//            ALUOp_i    - main-control ALU op class
//            funct_i    - R-type funct field
//            ALUCtrl_o  - registered ALU control code
//            valid_o    - ALUCtrl_o final, result usable
//            ready_i    - downstream consumes the issued op
//            stall_o    - multiply in progress
//            err_o      - sticky illegal-funct flag
// Params   : MUL_LAT    - multiply latency in cycles (1..15)
// Options  : ALU_CTRL_ILLEGAL_TRAP_EN - builds the sticky err_o flag;
//            when it is undefined, err_o is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module alu_ctrl_issue #(
  parameter int MUL_LAT = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic [1:0] ALUOp_i,
  input  logic [5:0] funct_i,
  output logic [3:0] ALUCtrl_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       stall_o,
  output logic       err_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    MUL_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] CODE_AND = 4'b0000;
  localparam logic [3:0] CODE_OR  = 4'b0001;
  localparam logic [3:0] CODE_ADD = 4'b0010;
  localparam logic [3:0] CODE_MUL = 4'b0011;
  localparam logic [3:0] CODE_SUB = 4'b0110;

  // The counter starts at MUL_LAT-1 so that the wait lasts exactly MUL_LAT
  // cycles, including the cycle in which it reaches zero.
  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [3:0] alu_ctrl, alu_ctrl_nxt;
  logic [3:0] dec_code;
  logic       dec_mul;
  logic       accept;

  // Field decode. Unrecognised funct values under ALUOp 10 fall back to add.
  always_comb begin
    dec_code = CODE_ADD;
    dec_mul  = 1'b0;
    case (ALUOp_i)
      2'b00: dec_code = CODE_ADD;
      2'b01: dec_code = CODE_SUB;
      2'b11: dec_code = CODE_OR;
      default: begin
        case (funct_i)
          6'b100000: dec_code = CODE_ADD;
          6'b100010: dec_code = CODE_SUB;
          6'b100100: dec_code = CODE_AND;
          6'b100101: dec_code = CODE_OR;
          6'b011000: begin
            dec_code = CODE_MUL;
            dec_mul  = 1'b1;
          end
          default:   dec_code = CODE_ADD;
        endcase
      end
    endcase
  end

  // In ISSUE a new op can only be taken when the current one retires, so
  // ready is passed straight through from downstream.
  always_comb begin
    ready_o = 1'b0;
    case (state)
      IDLE:    ready_o = 1'b1;
      ISSUE:   ready_o = ready_i;
      default: ready_o = 1'b0;
    endcase
    if (!rst_i) ready_o = 1'b0;
  end

  assign accept = valid_i && ready_o;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    alu_ctrl_nxt = alu_ctrl;
    if (accept) begin
      alu_ctrl_nxt = dec_code;
      if (dec_mul) begin
        state_nxt = MUL_WAIT;
        cnt_nxt   = CNT_INIT;
      end else begin
        state_nxt = ISSUE;
      end
    end else begin
      case (state)
        ISSUE: begin
          if (ready_i) state_nxt = IDLE;
        end
        MUL_WAIT: begin
          if (cnt == 4'd0) state_nxt = ISSUE;
          else             cnt_nxt   = cnt - 4'd1;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      alu_ctrl <= CODE_ADD;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      alu_ctrl <= alu_ctrl_nxt;
    end
  end

  assign ALUCtrl_o = alu_ctrl;
  assign valid_o   = (state == ISSUE);
  assign stall_o   = (state == MUL_WAIT);

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  logic funct_legal;
  logic illegal;
  logic err_q;

  assign funct_legal = (funct_i == 6'b100000) || (funct_i == 6'b100010) ||
                       (funct_i == 6'b100100) || (funct_i == 6'b100101) ||
                       (funct_i == 6'b011000);
  assign illegal     = (ALUOp_i == 2'b10) && !funct_legal;

  // Sticky until reset; later legal ops never clear it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                 err_q <= 1'b0;
    else if (accept && illegal) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_ctrl_issue
// Purpose  : Self-checking bench for alu_ctrl_issue. Expected ALUCtrl codes
//            are queued when an op is driven and popped when the DUT
//            completes an issue (valid_o && ready_i). Timing of stall, ready
//            and valid is checked against fixed cycle expectations. A second
//            instance with MUL_LAT=1 shares the stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_issue;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       valid_i;
  logic       ready_i;
  logic [1:0] ALUOp_i;
  logic [5:0] funct_i;

  logic       ready_o, valid_o, stall_o, err_o;
  logic [3:0] ALUCtrl_o;
  logic       ready1, valid1, stall1, err1;
  logic [3:0] alu_ctrl1;

  int vectors    = 0;
  int miscompares = 0;
  logic [3:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  alu_ctrl_issue #(.MUL_LAT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .ALUOp_i(ALUOp_i), .funct_i(funct_i), .ALUCtrl_o(ALUCtrl_o),
    .valid_o(valid_o), .ready_i(ready_i), .stall_o(stall_o), .err_o(err_o)
  );

  alu_ctrl_issue #(.MUL_LAT(1)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready1),
    .ALUOp_i(ALUOp_i), .funct_i(funct_i), .ALUCtrl_o(alu_ctrl1),
    .valid_o(valid1), .ready_i(ready_i), .stall_o(stall1), .err_o(err1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] exp);
    valid_i = 1'b1;
    ALUOp_i = op;
    funct_i = fn;
    exp_q.push_back(exp);
  endtask

  // Scoreboard: each completed issue must match the oldest queued code.
  always @(negedge clk_i) begin
    if (rst_i && valid_o && ready_i) begin
      if (exp_q.size() == 0) chk("unexpected_issue", {28'd0, ALUCtrl_o}, 32'hFFFF);
      else                   chk("issue_code", {28'd0, ALUCtrl_o}, {28'd0, exp_q.pop_front()});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_cnt1;
    logic [5:0] rfun[4];
    logic [3:0] rexp[4];
    rfun = '{6'h20, 6'h22, 6'h24, 6'h25};
    rexp = '{4'b0010, 4'b0110, 4'b0000, 4'b0001};

    rst_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1; ALUOp_i = 2'b00; funct_i = 6'h00;
    cyc(); cyc();
    chk("rst_ctrl",  {28'd0, ALUCtrl_o}, 32'h2);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_ready", {31'd0, ready_o}, 32'd0);
    chk("rst_err",   {31'd0, err_o},   32'd0);
    rst_i = 1'b1;
    cyc();

    // Single add
    drive(2'b00, 6'h00, 4'b0010);
    chk("add_ready", {31'd0, ready_o}, 32'd1);
    cyc();
    valid_i = 1'b0;
    chk("add_valid", {31'd0, valid_o}, 32'd1);
    chk("add_ctrl",  {28'd0, ALUCtrl_o}, 32'h2);
    cyc();
    chk("add_idle",  {31'd0, valid_o}, 32'd0);

    // Back-to-back R-type
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, rfun[i], rexp[i]);
      chk("b2b_ready", {31'd0, ready_o}, 32'd1);
      cyc();
      chk("b2b_valid", {31'd0, valid_o}, 32'd1);
      chk("b2b_ctrl",  {28'd0, ALUCtrl_o}, {28'd0, rexp[i]});
    end
    valid_i = 1'b0;
    cyc();
    chk("b2b_idle", {31'd0, valid_o}, 32'd0);

    // Multiply: 4 stall cycles on dut, 1 on dut1
    drive(2'b10, 6'h18, 4'b0011);
    chk("mul_ready_idle", {31'd0, ready_o}, 32'd1);
    cyc();
    valid_i = 1'b0;
    stall_cnt1 = 0;
    for (int k = 1; k <= 4; k++) begin
      chk("mul_stall", {31'd0, stall_o}, 32'd1);
      chk("mul_ready", {31'd0, ready_o}, 32'd0);
      chk("mul_valid", {31'd0, valid_o}, 32'd0);
      chk("mul_ctrl",  {28'd0, ALUCtrl_o}, 32'h3);
      if (stall1) stall_cnt1++;
      if (k == 1) begin
        chk("mul1_ctrl",  {28'd0, alu_ctrl1}, 32'h3);
        chk("mul1_ready", {31'd0, ready1}, 32'd0);
      end
      if (k == 2) chk("mul1_valid", {31'd0, valid1}, 32'd1);
      cyc();
    end
    chk("mul_done_valid", {31'd0, valid_o}, 32'd1);
    chk("mul_done_stall", {31'd0, stall_o}, 32'd0);
    chk("mul1_stall_cycles", stall_cnt1, 32'd1);
    cyc();
    chk("mul_idle", {31'd0, valid_o}, 32'd0);

    // Backpressure: sub held, then or waits for ready_i
    drive(2'b01, 6'h00, 4'b0110);
    ready_i = 1'b0;
    cyc();
    drive(2'b11, 6'h00, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid", {31'd0, valid_o}, 32'd1);
      chk("bp_ctrl",  {28'd0, ALUCtrl_o}, 32'h6);
      chk("bp_ready", {31'd0, ready_o}, 32'd0);
      cyc();
    end
    chk("bp_hold_ctrl", {28'd0, ALUCtrl_o}, 32'h6);
    ready_i = 1'b1;
    #1;
    chk("bp_ready_rel", {31'd0, ready_o}, 32'd1);
    cyc();
    valid_i = 1'b0;
    chk("bp_next_valid", {31'd0, valid_o}, 32'd1);
    chk("bp_next_ctrl",  {28'd0, ALUCtrl_o}, 32'h1);
    cyc();
    chk("bp_idle", {31'd0, valid_o}, 32'd0);

    // Reset during second MUL_WAIT cycle drops the op
    valid_i = 1'b1; ALUOp_i = 2'b10; funct_i = 6'h18;
    cyc();
    valid_i = 1'b0;
    cyc();
    chk("mrst_pre_stall", {31'd0, stall_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    chk("mrst_valid", {31'd0, valid_o}, 32'd0);
    chk("mrst_stall", {31'd0, stall_o}, 32'd0);
    chk("mrst_ctrl",  {28'd0, ALUCtrl_o}, 32'h2);
    chk("mrst_ready", {31'd0, ready_o}, 32'd0);
    cyc();
    rst_i = 1'b1;
    cyc();
    drive(2'b00, 6'h00, 4'b0010);
    chk("post_ready", {31'd0, ready_o}, 32'd1);
    cyc();
    valid_i = 1'b0;
    chk("post_valid", {31'd0, valid_o}, 32'd1);
    chk("post_ctrl",  {28'd0, ALUCtrl_o}, 32'h2);
    cyc();
    chk("post_idle", {31'd0, valid_o}, 32'd0);

    // Illegal funct, then a legal or
    drive(2'b10, 6'h3F, 4'b0010);
    cyc();
    chk("ill_ctrl",  {28'd0, ALUCtrl_o}, 32'h2);
    chk("ill_valid", {31'd0, valid_o}, 32'd1);
    chk("ill_err",   {31'd0, err_o}, {31'd0, EXP_ERR});
    drive(2'b11, 6'h00, 4'b0001);
    cyc();
    valid_i = 1'b0;
    chk("or_ctrl", {28'd0, ALUCtrl_o}, 32'h1);
    chk("or_err",  {31'd0, err_o}, {31'd0, EXP_ERR});
    chk("or_err1", {31'd0, err1},  {31'd0, EXP_ERR});
    cyc();
    cyc();
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
